shift_exec_stage: RTL and testbench
===================================

// Module: shift_exec_stage
// PURPOSE
//  Pipelined shift execution stage for the ALU datapath: accepts one shift op per cycle over a
//  valid/ready handshake, registers operands (S1), computes SLL/SRL/SRA (+optional rotates) and
//  registers the result (S2). Sits between decode/issue and writeback; absorbs writeback stalls.
// PARAMETERS
//  N      32  data width; only 32 is supported (shamt is $clog2(N)=5 bits)
//  TAG_W  5   width of opaque tag (destination reg id) carried alongside the op
// PORTS
//  clk        in   1        clock, rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  in_valid   in   1        upstream offers an op
//  in_ready   out  1        stage accepts op this cycle (combinational)
//  in_op      in   3        shift_op_t opcode
//  in_data    in   N        operand to shift
//  in_shamt   in   5        shift amount, 0..31
//  in_tag     in   TAG_W    passthrough tag
//  out_valid  out  1        result available
//  out_ready  in   1        downstream consumes result
//  out_data   out  N        shifted result
//  out_tag    out  TAG_W    tag of the result
//  out_err    out  1        op was illegal/not compiled in; out_data forced 0
// BEHAVIOUR
//  - Reset (rst_n=0, async): s1_valid=0, s2_valid=0, out_valid=0, out_data=0, out_tag=0,
//    out_err=0, all S1 registers 0. Ops in flight at reset are discarded; no partial output.
//  - Transfer on a port occurs iff valid&&ready at rising clk. Upstream holds in_* stable while
//    in_valid&&!in_ready; stage holds out_* stable while out_valid&&!out_ready.
//  - s2_adv = !s2_valid || out_ready;  s1_adv = !s1_valid || s2_adv;  in_ready = s1_adv.
//    No combinational path in_valid->out_valid; in_ready depends only on state and out_ready.
//  - Latency: accept at edge k -> out_valid at edge k+2 (no stall). Throughput 1 op/cycle.
//  - Back-pressure: with out_ready=0, S2 then S1 fill; in_ready=0 after 2 ops held. No op lost
//    or duplicated; order preserved. out_ready rising re-enables one stage per cycle in lockstep.
//  - S1->S2 on s1_adv&&s1_valid: S2 captures result of shift_core on S1 regs; if s1_adv and
//    !s1_valid, s2_valid clears (if consumed). Simultaneous accept+emit every cycle is legal.
//  - Ops: SLL=0 in<<sh; SRL=1 zero-fill >>; SRA=2 sign-fill >> (in[31] replicated);
//    ROL=3, ROR=4 (feature-gated); 5..7 illegal -> out_data=0, out_err=1.
//  - shamt=0 returns in_data unchanged for every legal op; shamt=31 is the max, no wrap beyond.
//  - Result width is exactly N; bits shifted out are dropped (rotates reinsert them).
// CONFIGURATION
//  - Macro SHIFT_EXEC_ROTATE_EN: defined -> ops 3/4 perform ROL/ROR (out_err=0).
//    Undefined -> ops 3/4 treated as illegal (out_data=0, out_err=1); rotate logic not built.
// STRUCTURE
//  - Package shift_pkg: typedef enum logic[2:0] shift_op_t {SHIFT_SLL=0,SHIFT_SRL=1,SHIFT_SRA=2,
//    SHIFT_ROL=3,SHIFT_ROR=4}; localparam SHIFT_N=32, SHIFT_SHAMT_W=5.
//  - Sub-module shift_core: purely combinational (op,data,shamt)->(result,err); the stage
//    itself holds only the S1/S2 registers and handshake logic.
// TESTING
//  - Reset: assert rst_n=0 mid-stream with 2 ops in flight -> out_valid=0, in_ready=1 next
//    cycle after release; no stale result ever emitted.
//  - Basic: SRL 0x8000_0000 sh=4 -> 0x0800_0000; SRA same -> 0xF800_0000; SLL 0x1 sh=31 ->
//    0x8000_0000; each out_valid exactly 2 cycles after accept, tag echoed.
//  - shamt=0 on SLL/SRL/SRA with 0xDEAD_BEEF -> 0xDEAD_BEEF, out_err=0.
//  - Stall: stream tags 1..6 with out_ready=0 for 5 cycles -> in_ready drops after tags 1,2
//    accepted; on release tags 1..6 emerge in order, one per cycle, none lost.
//  - Illegal op 7 with 0xFFFF_FFFF -> out_data=0, out_err=1; ROL 0x8000_0001 sh=1 -> 0x0000_0003
//    with SHIFT_EXEC_ROTATE_EN, else out_data=0, out_err=1.
//  - Random: 10k ops, random in_valid/out_ready throttling, compare to scoreboard model.

Source files
------------

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared opcode type and width constants for the shift execution stage
package shift_pkg;

    localparam int SHIFT_N       = 32;
    localparam int SHIFT_SHAMT_W = 5;

    typedef enum logic [2:0] {
        SHIFT_SLL = 3'd0,
        SHIFT_SRL = 3'd1,
        SHIFT_SRA = 3'd2,
        SHIFT_ROL = 3'd3,
        SHIFT_ROR = 3'd4
    } shift_op_t;

endpackage

// File: rtl/shift_core.sv
// rtl/shift_core.sv - combinational SLL/SRL/SRA shifter, ROL/ROR when SHIFT_EXEC_ROTATE_EN is defined
module shift_core
    import shift_pkg::*;
(
    input  logic [2:0]               op,
    input  logic [SHIFT_N-1:0]       data,
    input  logic [SHIFT_SHAMT_W-1:0] shamt,
    output logic [SHIFT_N-1:0]       result,
    output logic                     err
);

`ifdef SHIFT_EXEC_ROTATE_EN
    // Complement amount is 6 bits wide so shamt=0 shifts by 32 and contributes nothing
    logic [SHIFT_SHAMT_W:0] inv_shamt;
    assign inv_shamt = 6'd32 - {1'b0, shamt};
`endif

    always_comb begin
        result = '0;
        err    = 1'b0;
        case (shift_op_t'(op))
            SHIFT_SLL: result = data << shamt;
            SHIFT_SRL: result = data >> shamt;
            SHIFT_SRA: result = $unsigned($signed(data) >>> shamt);
`ifdef SHIFT_EXEC_ROTATE_EN
            SHIFT_ROL: result = (data << shamt) | (data >> inv_shamt);
            SHIFT_ROR: result = (data >> shamt) | (data << inv_shamt);
`endif
            default:   err = 1'b1;
        endcase
    end

endmodule

// File: rtl/shift_exec_stage.sv
// rtl/shift_exec_stage.sv - two-stage pipelined shift unit with valid/ready handshake (rotates via SHIFT_EXEC_ROTATE_EN)
module shift_exec_stage
    import shift_pkg::*;
#(
    parameter int N     = SHIFT_N,
    parameter int TAG_W = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_op,
    input  logic [N-1:0]             in_data,
    input  logic [SHIFT_SHAMT_W-1:0] in_shamt,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N-1:0]             out_data,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_err
);

    logic                     s1_valid;
    logic [2:0]               s1_op;
    logic [N-1:0]             s1_data;
    logic [SHIFT_SHAMT_W-1:0] s1_shamt;
    logic [TAG_W-1:0]         s1_tag;

    logic                     s1_adv;
    logic                     s2_adv;
    logic [N-1:0]             core_result;
    logic                     core_err;

    // out_valid is the S2 valid bit; ready ripples back from out_ready only
    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    shift_core u_core (
        .op     (s1_op),
        .data   (s1_data),
        .shamt  (s1_shamt),
        .result (core_result),
        .err    (core_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_op     <= '0;
            s1_data   <= '0;
            s1_shamt  <= '0;
            s1_tag    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
            out_err   <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_op    <= in_op;
                    s1_data  <= in_data;
                    s1_shamt <= in_shamt;
                    s1_tag   <= in_tag;
                end
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= core_result;
                    out_err  <= core_err;
                    out_tag  <= s1_tag;
                end
            end
        end
    end

endmodule

// File: tb/tb_shift_exec_stage.sv
// tb/tb_shift_exec_stage.sv - self-checking bench for shift_exec_stage (vector table, scoreboard, stall/reset/random)
module tb_shift_exec_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic        out_err;

    shift_exec_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_err   (out_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int ecnt = 0;
    always @(posedge clk) ecnt <= ecnt + 1;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] data;
        logic [4:0]  sh;
        logic [31:0] exp;
        logic        err;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic [4:0]  tag;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [2:0] op, input logic [31:0] d, input logic [4:0] sh,
                                  output logic [31:0] r, output logic e);
        int s;
        s = int'(sh);
        r = '0;
        e = 1'b0;
        case (op)
            3'd0: for (int i = 0; i < 32; i++) r[i] = (i >= s) ? d[i - s] : 1'b0;
            3'd1: for (int i = 0; i < 32; i++) r[i] = (i + s < 32) ? d[i + s] : 1'b0;
            3'd2: for (int i = 0; i < 32; i++) r[i] = (i + s < 32) ? d[i + s] : d[31];
`ifdef SHIFT_EXEC_ROTATE_EN
            3'd3: for (int i = 0; i < 32; i++) r[i] = d[(i - s + 32) % 32];
            3'd4: for (int i = 0; i < 32; i++) r[i] = d[(i + s) % 32];
`endif
            default: e = 1'b1;
        endcase
    endfunction

    task automatic set_in(input logic [2:0] op, input logic [31:0] d, input logic [4:0] sh, input logic [4:0] tag);
        in_op    = op;
        in_data  = d;
        in_shamt = sh;
        in_tag   = tag;
    endtask

    // Called just after a falling edge; resolves the transfers of the coming rising edge
    task automatic step(input logic v, input logic r, input bit lat, output bit acc, output bit fired);
        exp_t e;
        logic [31:0] md;
        logic        me;
        in_valid  = v;
        out_ready = r;
        #1;
        fired = out_valid && out_ready;
        if (fired) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL spurious_out: actual tag=%0h required=no output", out_tag);
            end else begin
                e = sb.pop_front();
                chk("out_data", out_data, e.data);
                chk("out_err", out_err, e.err);
                chk("out_tag", out_tag, e.tag);
                if (e.lat) chk("latency", ecnt + 1 - e.acc, 2);
            end
        end
        acc = v && in_ready;
        if (acc) begin
            model(in_op, in_data, in_shamt, md, me);
            e.data = md;
            e.err  = me;
            e.tag  = in_tag;
            e.acc  = ecnt + 1;
            e.lat  = lat;
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    vec_t vecs[13];

    initial begin
        bit a, f, pend;
        int t, fires, sent, cyc;

        vecs[0]  = '{3'd1, 32'h8000_0000, 5'd4,  32'h0800_0000, 1'b0};
        vecs[1]  = '{3'd2, 32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0};
        vecs[2]  = '{3'd0, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0};
        vecs[3]  = '{3'd0, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0};
        vecs[4]  = '{3'd1, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0};
        vecs[5]  = '{3'd2, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0};
        vecs[6]  = '{3'd7, 32'hFFFF_FFFF, 5'd5,  32'h0000_0000, 1'b1};
        vecs[7]  = '{3'd5, 32'h1234_5678, 5'd3,  32'h0000_0000, 1'b1};
`ifdef SHIFT_EXEC_ROTATE_EN
        vecs[8]  = '{3'd3, 32'h8000_0001, 5'd1,  32'h0000_0003, 1'b0};
        vecs[9]  = '{3'd4, 32'h8000_0001, 5'd1,  32'hC000_0000, 1'b0};
`else
        vecs[8]  = '{3'd3, 32'h8000_0001, 5'd1,  32'h0000_0000, 1'b1};
        vecs[9]  = '{3'd4, 32'h8000_0001, 5'd1,  32'h0000_0000, 1'b1};
`endif
        vecs[10] = '{3'd2, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 1'b0};
        vecs[11] = '{3'd1, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001, 1'b0};
        vecs[12] = '{3'd2, 32'hFFFF_FFFF, 5'd31, 32'hFFFF_FFFF, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_in(3'd0, 32'h0, 5'd0, 5'd0);
        @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Table vectors, back to back; expected values are the table's own constants
        for (int i = 0; i < 13; i++) begin
            exp_t e;
            set_in(vecs[i].op, vecs[i].data, vecs[i].sh, 5'(i));
            step(1'b1, 1'b1, 1'b1, a, f);
            chk("vec_accept", a, 1);
            if (a) begin
                e = sb.pop_back();
                e.data = vecs[i].exp;
                e.err  = vecs[i].err;
                sb.push_back(e);
            end
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, a, f);
        chk("vec_drain", sb.size(), 0);

        // Stall: tags 1..6 against a blocked output
        t = 1;
        for (int c = 0; c < 5; c++) begin
            set_in(3'd0, 32'h100 * t, 5'd1, 5'(t));
            if (c >= 2) chk("stall_in_ready", in_ready, 0);
            step(1'b1, 1'b0, 1'b0, a, f);
            if (a) t++;
        end
        chk("stall_accepted", t - 1, 2);
        fires = 0;
        for (int c = 0; c < 6; c++) begin
            set_in(3'd0, 32'h100 * t, 5'd1, 5'(t));
            step(t <= 6, 1'b1, 1'b0, a, f);
            if (a) t++;
            if (f) fires++;
        end
        chk("stall_fires", fires, 6);
        chk("stall_drain", sb.size(), 0);

        // Reset with two ops in flight
        set_in(3'd1, 32'hAAAA_5555, 5'd3, 5'd9);
        step(1'b1, 1'b1, 1'b0, a, f);
        set_in(3'd2, 32'h5555_AAAA, 5'd2, 5'd10);
        step(1'b1, 1'b1, 1'b0, a, f);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        sb.delete();
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("postrst_out_valid", out_valid, 0);
        chk("postrst_in_ready", in_ready, 1);
        @(negedge clk);
        fires = 0;
        for (int c = 0; c < 4; c++) begin
            step(1'b0, 1'b1, 1'b0, a, f);
            if (f) fires++;
        end
        chk("postrst_no_stale", fires, 0);

        // Random traffic with throttling on both sides
        pend = 1'b0;
        sent = 0;
        cyc  = 0;
        while (sent < 10000 && cyc < 60000) begin
            if (!pend && $urandom_range(3) != 0) begin
                set_in(3'($urandom_range(7)), $urandom, 5'($urandom_range(31)), 5'($urandom_range(31)));
                pend = 1'b1;
            end
            step(pend, $urandom_range(3) != 0, 1'b0, a, f);
            if (a) begin
                pend = 1'b0;
                sent++;
            end
            cyc++;
        end
        chk("random_sent", sent, 10000);
        cyc = 0;
        while (sb.size() > 0 && cyc < 100) begin
            step(1'b0, 1'b1, 1'b0, a, f);
            cyc++;
        end
        chk("random_drain", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
